wash_program_cfg: RTL and testbench
===================================

// Module: wash_program_cfg
// PURPOSE
//  Parametrised program/configuration unit for the washer controller. In setST it cycles preset
//  programs (WRD,W,WR,R,RD,D,custom) and edits custom water level and rinse count.
//  It derives registered per-phase durations and a total, then hands the frozen config to the run
//  controller via a valid/ready handshake. Sits between key/state logic and the run/display timers.
// PARAMETERS
//  TIME_W     6  width of each phase-duration output (minutes)
//  WATER_W    3  width of water_level
//  WATER_MIN  1  lowest custom water level
//  WATER_MAX  7  highest custom water level (saturates, no wrap)
//  WATER_DEF  3  water level after reset/beginST/preset change
//  RINSE_MAX  3  max rinse repetitions (custom cycles 1..RINSE_MAX)
//  WASH_BASE  2  wash_time = WASH_BASE + water_level
//  RINSE_BASE 1  rinse_time = rinse_cnt * (RINSE_BASE + water_level)
//  DRY_T      5  dry_time constant
// PORTS
//  cp          in   1          clock, all logic on posedge
//  rst_n       in   1          synchronous active-low reset
//  state       in   3          system state: 0 shutDown,1 begin,2 set,3 run,4 error,5 pause,6 finish
//  click       in   1          select key level; internally rising-edge detected
//  water_btn   in   1          modifier: click edge -> water_level +1
//  rinse_btn   in   1          modifier: click edge -> rinse_cnt step
//  start_req   in   1          level; rising edge in EDIT requests hand-off
//  load_ready  in   1          run controller accepts config
//  load_valid  out  1          config offered, stable while high
//  cfg_locked  out  1          config frozen for run
//  prog_idx    out  3          0 WRD,1 W,2 WR,3 R,4 RD,5 D,6 custom
//  phase_mask  out  3          {wash,rinse,dry} enables
//  water_level out  WATER_W    current water level
//  rinse_cnt   out  2          rinse repetitions (0 when rinse disabled)
//  wash_time / rinse_time / dry_time  out  TIME_W  phase durations
//  total_time  out  TIME_W+2   wash+rinse+dry
//  led_mask    out  3          phase_mask in EDIT/OFFER, else 0
// BEHAVIOUR
//  Reset (rst_n=0 at cp): FSM IDLE, prog_idx 0, water WATER_DEF, rinse_cnt 1, load_valid 0,
//   cfg_locked 0, click/start edge regs 0; times = defaults (5,4,5, total 14).
//  Edge: ev = click & ~click_q; sv = start_req & ~start_q; held levels give one event only.
//  FSM: IDLE -> EDIT when state==2. IDLE & state==1: load defaults (see CONFIGURATION).
//   EDIT: ev&water_btn: prog 6, water=min(water+1,WATER_MAX). ev&rinse_btn&!water_btn: prog 6,
//    rinse_cnt 1..RINSE_MAX wrapping to 1. ev with neither: prog=(prog==6)?0:prog+1,
//    water=WATER_DEF, rinse_cnt=1. Both buttons: water wins. sv -> OFFER (load_valid=1 next cp).
//    state!=2 while EDIT -> IDLE, no offer.
//   OFFER: all edits ignored; load_valid held. load_valid&load_ready at cp -> LOCK: load_valid 0,
//    cfg_locked 1 next cycle. state in {0,1} -> IDLE, load_valid drops next cycle.
//   LOCK: config frozen. state 4/5 keep lock; state 6,0 or 1 -> IDLE, cfg_locked 0.
//  phase_mask per prog: 0 111,1 100,2 110,3 010,4 011,5 001,6 111; disabled phase -> time 0.
//  Times registered, 1-cycle latency after any config change; each saturates at 2^TIME_W-1;
//   total_time full-width sum, never overflows. Simultaneous ev and sv in EDIT: edit applied,
//   OFFER entered same cp; times settle before load_ready can complete (>=1 cycle valid).
//  Reset mid-OFFER/LOCK: immediate return to reset values, handshake abandoned.
// CONFIGURATION
//  WASH_SEL_MEMORY_EN defined: each LOCK entry snapshots prog/water/rinse; beginST in IDLE
//   restores the snapshot (reset clears snapshot to defaults).
//  Undefined: beginST always loads prog 0, WATER_DEF, rinse 1.
// TESTING
//  Reset, state=2, 7 click pulses -> prog 1..6 then 0; prog 2: times 5,4,0 total 9.
//  prog 6, 6 pulses with water_btn from 3 -> water 4,5,6,7,7,7; wash 9, rinse 8, total 22.
//  prog 6, rinse_btn x3 at water 3 -> rinse_cnt 2,3,1; rinse_time 8,12,4 one cycle after each.
//  start edge, load_ready low 5 cycles -> load_valid high 5, clicks ignored; ready -> locked 1.
//  LOCK then state 5 -> still locked; state 6 -> cfg_locked 0, FSM IDLE.
//  MEMORY_EN: lock prog 4, state 1 -> prog 4 restored; without macro -> prog 0.

Source files
------------

// File: rtl/wash_program_cfg.sv
// ---------------------------------------------------------------------------
// wash_program_cfg
//
// Program / configuration unit for the washer controller. While the system is
// in the set state it steps through the preset programs (WRD, W, WR, R, RD, D,
// custom) and lets the user edit the custom water level and rinse count. It
// derives registered per-phase durations plus their total, and hands the
// frozen configuration to the run controller through a valid/ready handshake.
//
// Optional feature (compile-time macro WASH_SEL_MEMORY_EN):
//   defined   - every lock captures prog/water/rinse; beginST in IDLE restores
//               that capture (reset clears it to the defaults).
//   undefined - beginST in IDLE always loads prog 0, WATER_DEF, rinse 1.
//
// Ports:
//   i_cp            clock, all logic on the rising edge
//   i_rst_n         synchronous active-low reset
//   i_state   [2:0] system state: 0 shutDown,1 begin,2 set,3 run,4 error,
//                   5 pause,6 finish
//   i_click         select key level (rising edge detected here)
//   i_water_btn     modifier: click edge -> water level +1
//   i_rinse_btn     modifier: click edge -> rinse count step
//   i_start_req     level; a rising edge while editing requests hand-off
//   i_load_ready    run controller accepts the offered configuration
//   o_load_valid    configuration offered, stable while high
//   o_cfg_locked    configuration frozen for the run
//   o_prog_idx[2:0] 0 WRD,1 W,2 WR,3 R,4 RD,5 D,6 custom
//   o_phase_mask    {wash,rinse,dry} enables
//   o_water_level   current water level
//   o_rinse_cnt     rinse repetitions (0 when rinse phase is disabled)
//   o_wash_time / o_rinse_time / o_dry_time   phase durations (minutes)
//   o_total_time    wash + rinse + dry, full width
//   o_led_mask      phase mask while editing/offering, otherwise 0
// ---------------------------------------------------------------------------
module wash_program_cfg #(
  parameter int unsigned TIME_W     = 6,
  parameter int unsigned WATER_W    = 3,
  parameter int unsigned WATER_MIN  = 1,
  parameter int unsigned WATER_MAX  = 7,
  parameter int unsigned WATER_DEF  = 3,
  parameter int unsigned RINSE_MAX  = 3,
  parameter int unsigned WASH_BASE  = 2,
  parameter int unsigned RINSE_BASE = 1,
  parameter int unsigned DRY_T      = 5
) (
  input  logic                i_cp,
  input  logic                i_rst_n,
  input  logic [2:0]          i_state,
  input  logic                i_click,
  input  logic                i_water_btn,
  input  logic                i_rinse_btn,
  input  logic                i_start_req,
  input  logic                i_load_ready,
  output logic                o_load_valid,
  output logic                o_cfg_locked,
  output logic [2:0]          o_prog_idx,
  output logic [2:0]          o_phase_mask,
  output logic [WATER_W-1:0]  o_water_level,
  output logic [1:0]          o_rinse_cnt,
  output logic [TIME_W-1:0]   o_wash_time,
  output logic [TIME_W-1:0]   o_rinse_time,
  output logic [TIME_W-1:0]   o_dry_time,
  output logic [TIME_W+1:0]   o_total_time,
  output logic [2:0]          o_led_mask
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EDIT  = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam logic [2:0] ST_SHUTDOWN = 3'd0;
  localparam logic [2:0] ST_BEGIN    = 3'd1;
  localparam logic [2:0] ST_SET      = 3'd2;
  localparam logic [2:0] ST_ERROR    = 3'd4;
  localparam logic [2:0] ST_PAUSE    = 3'd5;

  localparam logic [2:0]         PROG_CUSTOM = 3'd6;
  localparam int unsigned        TIME_MAX    = (1 << TIME_W) - 1;
  localparam logic [WATER_W-1:0] WATER_DEF_V = WATER_W'(WATER_DEF);
  localparam logic [WATER_W-1:0] WATER_MAX_V = WATER_W'(WATER_MAX);
  localparam logic [1:0]         RINSE_MAX_V = 2'(RINSE_MAX);

  function automatic logic [2:0] mask_of(input logic [2:0] prog);
    logic [2:0] m;
    case (prog)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b100;
      3'd2:    m = 3'b110;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b011;
      3'd5:    m = 3'b001;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [TIME_W-1:0] sat_time(input logic [31:0] v);
    if (v > 32'(TIME_MAX)) return TIME_W'(TIME_MAX);
    return v[TIME_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] wash_of(input logic [2:0] prog,
                                                input logic [WATER_W-1:0] water);
    logic [2:0] m;
    m = mask_of(prog);
    if (!m[2]) return '0;
    return sat_time(32'(WASH_BASE) + 32'(water));
  endfunction

  function automatic logic [TIME_W-1:0] rinse_of(input logic [2:0] prog,
                                                 input logic [WATER_W-1:0] water,
                                                 input logic [1:0] rinse);
    logic [2:0] m;
    m = mask_of(prog);
    if (!m[1]) return '0;
    return sat_time(32'(rinse) * (32'(RINSE_BASE) + 32'(water)));
  endfunction

  function automatic logic [TIME_W-1:0] dry_of(input logic [2:0] prog);
    logic [2:0] m;
    m = mask_of(prog);
    if (!m[0]) return '0;
    return sat_time(32'(DRY_T));
  endfunction

  // Water level saturates at the top; the floor is held by WATER_MIN.
  function automatic logic [WATER_W-1:0] water_inc(input logic [WATER_W-1:0] w);
    if (w >= WATER_MAX_V) return WATER_MAX_V;
    if (32'(w) < WATER_MIN) return WATER_W'(WATER_MIN);
    return w + 1'b1;
  endfunction

  function automatic logic [1:0] rinse_step(input logic [1:0] r);
    if (r >= RINSE_MAX_V) return 2'd1;
    return r + 2'd1;
  endfunction

  logic [1:0]         r_fsm;
  logic [2:0]         r_prog;
  logic [WATER_W-1:0] r_water;
  logic [1:0]         r_rinse;
  logic               r_load_valid;
  logic               r_cfg_locked;
  logic               r_settled;
  logic               r_click_q;
  logic               r_start_q;
  logic [TIME_W-1:0]  r_wash_t;
  logic [TIME_W-1:0]  r_rinse_t;
  logic [TIME_W-1:0]  r_dry_t;
  logic [TIME_W+1:0]  r_total_t;

`ifdef WASH_SEL_MEMORY_EN
  logic [2:0]         r_snap_prog;
  logic [WATER_W-1:0] r_snap_water;
  logic [1:0]         r_snap_rinse;
`endif

  logic               w_ev;
  logic               w_sv;
  logic [2:0]         w_mask;
  logic [TIME_W-1:0]  w_wash_n;
  logic [TIME_W-1:0]  w_rinse_n;
  logic [TIME_W-1:0]  w_dry_n;
  logic [TIME_W+1:0]  w_total_n;
  logic               w_hs;

  assign w_ev   = i_click & ~r_click_q;
  assign w_sv   = i_start_req & ~r_start_q;
  assign w_mask = mask_of(r_prog);

  assign w_wash_n  = wash_of(r_prog, r_water);
  assign w_rinse_n = rinse_of(r_prog, r_water, r_rinse);
  assign w_dry_n   = dry_of(r_prog);
  assign w_total_n = (TIME_W+2)'(w_wash_n) + (TIME_W+2)'(w_rinse_n) + (TIME_W+2)'(w_dry_n);

  // The handshake only completes once the offer has been up for a full cycle,
  // so the registered durations already reflect any edit made on entry.
  assign w_hs = r_load_valid & i_load_ready & r_settled;

  // Edge detectors for the key and start levels
  always_ff @(posedge i_cp) begin
    if (!i_rst_n) begin
      r_click_q <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_click_q <= i_click;
      r_start_q <= i_start_req;
    end
  end

  // Program FSM and configuration registers
  always_ff @(posedge i_cp) begin
    if (!i_rst_n) begin
      r_fsm        <= S_IDLE;
      r_prog       <= 3'd0;
      r_water      <= WATER_DEF_V;
      r_rinse      <= 2'd1;
      r_load_valid <= 1'b0;
      r_cfg_locked <= 1'b0;
      r_settled    <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_load_valid <= 1'b0;
          r_cfg_locked <= 1'b0;
          if (i_state == ST_SET) begin
            r_fsm <= S_EDIT;
          end else if (i_state == ST_BEGIN) begin
`ifdef WASH_SEL_MEMORY_EN
            r_prog  <= r_snap_prog;
            r_water <= r_snap_water;
            r_rinse <= r_snap_rinse;
`else
            r_prog  <= 3'd0;
            r_water <= WATER_DEF_V;
            r_rinse <= 2'd1;
`endif
          end
        end

        S_EDIT: begin
          if (i_state != ST_SET) begin
            r_fsm <= S_IDLE;
          end else begin
            if (w_ev) begin
              if (i_water_btn) begin
                r_prog  <= PROG_CUSTOM;
                r_water <= water_inc(r_water);
              end else if (i_rinse_btn) begin
                r_prog  <= PROG_CUSTOM;
                r_rinse <= rinse_step(r_rinse);
              end else begin
                r_prog  <= (r_prog == PROG_CUSTOM) ? 3'd0 : r_prog + 3'd1;
                r_water <= WATER_DEF_V;
                r_rinse <= 2'd1;
              end
            end
            if (w_sv) begin
              r_fsm        <= S_OFFER;
              r_load_valid <= 1'b1;
              r_settled    <= 1'b0;
            end
          end
        end

        S_OFFER: begin
          r_settled <= 1'b1;
          if (i_state == ST_SHUTDOWN || i_state == ST_BEGIN) begin
            r_fsm        <= S_IDLE;
            r_load_valid <= 1'b0;
          end else if (w_hs) begin
            r_fsm        <= S_LOCK;
            r_load_valid <= 1'b0;
            r_cfg_locked <= 1'b1;
          end
        end

        default: begin
          // Error and pause keep the lock; run/set also leave it untouched.
          if (i_state != ST_ERROR && i_state != ST_PAUSE &&
              (i_state == 3'd6 || i_state == ST_SHUTDOWN || i_state == ST_BEGIN)) begin
            r_fsm        <= S_IDLE;
            r_cfg_locked <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef WASH_SEL_MEMORY_EN
  // Snapshot taken on every entry into LOCK
  always_ff @(posedge i_cp) begin
    if (!i_rst_n) begin
      r_snap_prog  <= 3'd0;
      r_snap_water <= WATER_DEF_V;
      r_snap_rinse <= 2'd1;
    end else if (r_fsm == S_OFFER && w_hs &&
                 i_state != ST_SHUTDOWN && i_state != ST_BEGIN) begin
      r_snap_prog  <= r_prog;
      r_snap_water <= r_water;
      r_snap_rinse <= r_rinse;
    end
  end
`endif

  // Registered durations, one cycle behind the configuration
  always_ff @(posedge i_cp) begin
    if (!i_rst_n) begin
      r_wash_t  <= wash_of(3'd0, WATER_DEF_V);
      r_rinse_t <= rinse_of(3'd0, WATER_DEF_V, 2'd1);
      r_dry_t   <= dry_of(3'd0);
      r_total_t <= (TIME_W+2)'(wash_of(3'd0, WATER_DEF_V)) +
                   (TIME_W+2)'(rinse_of(3'd0, WATER_DEF_V, 2'd1)) +
                   (TIME_W+2)'(dry_of(3'd0));
    end else begin
      r_wash_t  <= w_wash_n;
      r_rinse_t <= w_rinse_n;
      r_dry_t   <= w_dry_n;
      r_total_t <= w_total_n;
    end
  end

  assign o_load_valid  = r_load_valid;
  assign o_cfg_locked  = r_cfg_locked;
  assign o_prog_idx    = r_prog;
  assign o_phase_mask  = w_mask;
  assign o_water_level = r_water;
  assign o_rinse_cnt   = w_mask[1] ? r_rinse : 2'd0;
  assign o_wash_time   = r_wash_t;
  assign o_rinse_time  = r_rinse_t;
  assign o_dry_time    = r_dry_t;
  assign o_total_time  = r_total_t;
  assign o_led_mask    = (r_fsm == S_EDIT || r_fsm == S_OFFER) ? w_mask : 3'b000;

endmodule

// File: tb/tb_wash_program_cfg.sv
module tb_wash_program_cfg;
  logic       cp = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic       click, water_btn, rinse_btn, start_req, load_ready;
  logic       load_valid, cfg_locked;
  logic [2:0] prog_idx, phase_mask, led_mask;
  logic [2:0] water_level;
  logic [1:0] rinse_cnt;
  logic [5:0] wash_time, rinse_time, dry_time;
  logic [7:0] total_time;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cp = ~cp;

  wash_program_cfg dut (
    .i_cp(cp), .i_rst_n(rst_n), .i_state(state), .i_click(click),
    .i_water_btn(water_btn), .i_rinse_btn(rinse_btn), .i_start_req(start_req),
    .i_load_ready(load_ready), .o_load_valid(load_valid), .o_cfg_locked(cfg_locked),
    .o_prog_idx(prog_idx), .o_phase_mask(phase_mask), .o_water_level(water_level),
    .o_rinse_cnt(rinse_cnt), .o_wash_time(wash_time), .o_rinse_time(rinse_time),
    .o_dry_time(dry_time), .o_total_time(total_time), .o_led_mask(led_mask)
  );

  task automatic tick;
    @(posedge cp); #1;
  endtask

  task automatic pulse_click(input logic w, input logic r);
    water_btn = w; rinse_btn = r; click = 1'b1;
    tick;
    click = 1'b0;
    tick;
    water_btn = 1'b0; rinse_btn = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; state = 3'd0; click = 0; water_btn = 0; rinse_btn = 0;
    start_req = 0; load_ready = 0;
    tick; tick;
    n_checks++;
    if (prog_idx !== 3'd0 || water_level !== 3'd3 || rinse_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_cfg: prog=%0d water=%0d rinse=%0d expected 0 3 1", prog_idx, water_level, rinse_cnt);
    end
    n_checks++;
    if (load_valid !== 1'b0 || cfg_locked !== 1'b0 || led_mask !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: valid=%b locked=%b led=%b expected 0 0 000", load_valid, cfg_locked, led_mask);
    end
    n_checks++;
    if (wash_time !== 6'd5 || rinse_time !== 6'd4 || dry_time !== 6'd5 || total_time !== 8'd14) begin
      n_fail++;
      $display("FAIL reset_times: %0d %0d %0d total %0d expected 5 4 5 14", wash_time, rinse_time, dry_time, total_time);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_prog_cycle;
    state = 3'd2;
    tick;
    for (int i = 0; i < 7; i++) begin
      pulse_click(1'b0, 1'b0);
      n_checks++;
      if (prog_idx !== 3'((i + 1) % 7)) begin
        n_fail++;
        $display("FAIL prog_cycle[%0d]: prog=%0d expected %0d", i, prog_idx, (i + 1) % 7);
      end
      if (i == 1) begin
        n_checks++;
        if (wash_time !== 6'd5 || rinse_time !== 6'd4 || dry_time !== 6'd0 || total_time !== 8'd9 ||
            phase_mask !== 3'b110 || led_mask !== 3'b110) begin
          n_fail++;
          $display("FAIL prog2_times: %0d %0d %0d total %0d mask %b led %b expected 5 4 0 9 110 110",
                   wash_time, rinse_time, dry_time, total_time, phase_mask, led_mask);
        end
      end
    end
  endtask

  task automatic test_water;
    logic [2:0] exp_w [6];
    exp_w = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    for (int i = 0; i < 6; i++) begin
      pulse_click(1'b1, 1'b0);
      n_checks++;
      if (water_level !== exp_w[i] || prog_idx !== 3'd6) begin
        n_fail++;
        $display("FAIL water[%0d]: water=%0d prog=%0d expected %0d 6", i, water_level, prog_idx, exp_w[i]);
      end
    end
    n_checks++;
    if (wash_time !== 6'd9 || rinse_time !== 6'd8 || dry_time !== 6'd5 || total_time !== 8'd22) begin
      n_fail++;
      $display("FAIL water_times: %0d %0d %0d total %0d expected 9 8 5 22", wash_time, rinse_time, dry_time, total_time);
    end
  endtask

  task automatic test_rinse;
    logic [1:0] exp_c [3];
    logic [5:0] exp_t [3];
    exp_c = '{2'd2, 2'd3, 2'd1};
    exp_t = '{6'd8, 6'd12, 6'd4};
    pulse_click(1'b0, 1'b0);  // custom -> WRD, water back to 3
    for (int i = 0; i < 3; i++) begin
      rinse_btn = 1'b1; click = 1'b1;
      tick;
      n_checks++;
      if (rinse_cnt !== exp_c[i] || prog_idx !== 3'd6) begin
        n_fail++;
        $display("FAIL rinse_cnt[%0d]: cnt=%0d prog=%0d expected %0d 6", i, rinse_cnt, prog_idx, exp_c[i]);
      end
      click = 1'b0; rinse_btn = 1'b0;
      tick;
      n_checks++;
      if (rinse_time !== exp_t[i]) begin
        n_fail++;
        $display("FAIL rinse_time[%0d]: got %0d expected %0d", i, rinse_time, exp_t[i]);
      end
    end
    pulse_click(1'b1, 1'b1);  // both buttons: water wins
    n_checks++;
    if (water_level !== 3'd4 || rinse_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL both_btns: water=%0d rinse=%0d expected 4 1", water_level, rinse_cnt);
    end
  endtask

  task automatic test_offer;
    for (int i = 0; i < 5; i++) pulse_click(1'b0, 1'b0);  // 6 -> 0 -> 4
    n_checks++;
    if (prog_idx !== 3'd4 || phase_mask !== 3'b011 || wash_time !== 6'd0 || rinse_time !== 6'd4 ||
        dry_time !== 6'd5 || total_time !== 8'd9) begin
      n_fail++;
      $display("FAIL prog4: prog=%0d mask=%b %0d %0d %0d total %0d expected 4 011 0 4 5 9",
               prog_idx, phase_mask, wash_time, rinse_time, dry_time, total_time);
    end
    start_req = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      click = ~click;
      n_checks++;
      if (load_valid !== 1'b1 || cfg_locked !== 1'b0 || prog_idx !== 3'd4 || led_mask !== 3'b011) begin
        n_fail++;
        $display("FAIL offer_hold[%0d]: valid=%b locked=%b prog=%0d led=%b expected 1 0 4 011",
                 i, load_valid, cfg_locked, prog_idx, led_mask);
      end
      tick;
    end
    click = 1'b0;
    load_ready = 1'b1;
    tick;
    load_ready = 1'b0;
    n_checks++;
    if (load_valid !== 1'b0 || cfg_locked !== 1'b1 || led_mask !== 3'b000 || prog_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL lock: valid=%b locked=%b led=%b prog=%0d expected 0 1 000 4", load_valid, cfg_locked, led_mask, prog_idx);
    end
    start_req = 1'b0;
  endtask

  task automatic test_lock_states;
    state = 3'd5; tick; tick; tick;
    n_checks++;
    if (cfg_locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_pause: locked=%b expected 1", cfg_locked);
    end
    state = 3'd4; tick;
    n_checks++;
    if (cfg_locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_error: locked=%b expected 1", cfg_locked);
    end
    state = 3'd6; tick;
    n_checks++;
    if (cfg_locked !== 1'b0 || prog_idx !== 3'd4) begin
      n_fail++; $display("FAIL lock_finish: locked=%b prog=%0d expected 0 4", cfg_locked, prog_idx);
    end
  endtask

  task automatic test_memory;
    logic [2:0] exp_p;
    logic [7:0] exp_tot;
`ifdef WASH_SEL_MEMORY_EN
    exp_p = 3'd4; exp_tot = 8'd9;
`else
    exp_p = 3'd0; exp_tot = 8'd14;
`endif
    state = 3'd2; tick;
    pulse_click(1'b0, 1'b0);
    n_checks++;
    if (prog_idx !== 3'd5) begin
      n_fail++; $display("FAIL reedit: prog=%0d expected 5", prog_idx);
    end
    state = 3'd1; tick; tick; tick;
    n_checks++;
    if (prog_idx !== exp_p || water_level !== 3'd3 || rinse_cnt !== 2'd1 || total_time !== exp_tot) begin
      n_fail++;
      $display("FAIL begin_load: prog=%0d water=%0d rinse=%0d total=%0d expected %0d 3 1 %0d",
               prog_idx, water_level, rinse_cnt, total_time, exp_p, exp_tot);
    end
  endtask

  task automatic test_simul_abandon;
    logic [2:0] exp_p;
`ifdef WASH_SEL_MEMORY_EN
    exp_p = 3'd5;
`else
    exp_p = 3'd1;
`endif
    state = 3'd2; tick;
    click = 1'b1; start_req = 1'b1;
    tick;
    click = 1'b0;
    n_checks++;
    if (prog_idx !== exp_p || load_valid !== 1'b1) begin
      n_fail++; $display("FAIL simul_ev_sv: prog=%0d valid=%b expected %0d 1", prog_idx, load_valid, exp_p);
    end
    tick;
    n_checks++;
    if (total_time !== 8'd5) begin
      n_fail++; $display("FAIL simul_total: total=%0d expected 5", total_time);
    end
    state = 3'd1; tick;
    n_checks++;
    if (load_valid !== 1'b0 || cfg_locked !== 1'b0) begin
      n_fail++; $display("FAIL abandon: valid=%b locked=%b expected 0 0", load_valid, cfg_locked);
    end
    start_req = 1'b0;
  endtask

  task automatic test_reset_mid_lock;
    state = 3'd2; tick; tick;
    start_req = 1'b1; tick;
    load_ready = 1'b1; tick;
    n_checks++;
    if (load_valid !== 1'b1 || cfg_locked !== 1'b0) begin
      n_fail++; $display("FAIL min_valid: valid=%b locked=%b expected 1 0", load_valid, cfg_locked);
    end
    tick;
    load_ready = 1'b0; start_req = 1'b0;
    n_checks++;
    if (cfg_locked !== 1'b1) begin
      n_fail++; $display("FAIL lock2: locked=%b expected 1", cfg_locked);
    end
    rst_n = 1'b0; tick;
    n_checks++;
    if (cfg_locked !== 1'b0 || load_valid !== 1'b0 || prog_idx !== 3'd0 || total_time !== 8'd14) begin
      n_fail++;
      $display("FAIL reset_mid_lock: locked=%b valid=%b prog=%0d total=%0d expected 0 0 0 14",
               cfg_locked, load_valid, prog_idx, total_time);
    end
    rst_n = 1'b1; tick;
  endtask

  initial begin
    test_reset;
    test_prog_cycle;
    test_water;
    test_rinse;
    test_offer;
    test_lock_states;
    test_memory;
    test_simul_abandon;
    test_reset_mid_lock;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
